tdpram_pa_rmw_ctrl: RTL and testbench

Port-A front end for the true-dual-port RAM core, which has no byte enables.
- Accepts byte-enabled read/write requests over a valid/ready handshake.
- Full-mask writes go straight to the RAM.
- Partial-mask writes become a 2-cycle read-modify-write.
- Reads return data one cycle after acceptance.
- Drives the RAM's port A signals (wr/addr/wdata) directly; consumes its registered rdata.

---
 rtl/tdpram_pkg.sv | 20 ++
 rtl/tdpram_pa_rmw_ctrl_if.sv | 35 +++
 rtl/tdpram_be_merge.sv | 28 ++
 rtl/tdpram_pa_rmw_ctrl.sv | 147 ++++++++++++++
 tb/tb_tdpram_pa_rmw_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/tdpram_pkg.sv
// Shared definitions for the true-dual-port RAM front ends: FSM state
// encodings and the byte-enable width derivation.
// Optional feature macro: TDPRAM_PA_INIT_CLR_EN adds the S_INIT clear sweep state.
package tdpram_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MERGE = 2'd1
`ifdef TDPRAM_PA_INIT_CLR_EN
    ,
    S_INIT  = 2'd2
`endif
  } state_e;

  // One byte-enable bit per data byte.
  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/tdpram_pa_rmw_ctrl_if.sv
// Port-A request/response bus plus the RAM port-A signals.
// slave modport is the controller's view; master is the client/RAM side.
interface tdpram_pa_rmw_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  import tdpram_pkg::*;

  localparam int BW = be_width(DW);

  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_be;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  modport slave (
    input  req_valid, req_wr, req_addr, req_be, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_wr, ram_addr, ram_wdata, busy
  );

  modport master (
    output req_valid, req_wr, req_addr, req_be, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ram_wr, ram_addr, ram_wdata, busy
  );

endinterface

// File: rtl/tdpram_be_merge.sv
// Byte-lane merge: each byte comes from new_i where its enable is set,
// otherwise from old_i. Purely combinational; shared with port-B controllers.
module tdpram_be_merge
  import tdpram_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]           old_i,
  input  logic [DW-1:0]           new_i,
  input  logic [be_width(DW)-1:0] be_i,
  output logic [DW-1:0]           merged_o
);

  localparam int BW = be_width(DW);

  // Select each byte lane independently from old or new data.
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < BW; i++) begin
      if (be_i[i]) begin
        merged_o[8*i +: 8] = new_i[8*i +: 8];
      end else begin
        merged_o[8*i +: 8] = old_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/tdpram_pa_rmw_ctrl.sv
// Port-A front end for a RAM without byte enables. Full-mask writes go
// straight through, partial-mask writes become a read-then-merge-write pair,
// reads respond one cycle after acceptance.
// Optional feature macro: TDPRAM_PA_INIT_CLR_EN (clear-to-zero sweep after reset).
module tdpram_pa_rmw_ctrl
  import tdpram_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 2 ** AW
) (
  input  logic                  clk_pa,
  input  logic                  rst_n,
  tdpram_pa_rmw_ctrl_if.slave   bus
);

  localparam int            BW      = be_width(DW);
  localparam logic [BW-1:0] BE_FULL = {BW{1'b1}};
  localparam logic [BW-1:0] BE_NONE = {BW{1'b0}};

  if (DEPTH != (2 ** AW)) begin : g_depth_chk
    $error("DEPTH must equal 2**AW");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [BW-1:0] be_q,    be_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] merged_s;
  logic          ready_s, busy_s, ram_wr_s;
  logic [AW-1:0] ram_addr_s;
  logic [DW-1:0] ram_wdata_s;
`ifdef TDPRAM_PA_INIT_CLR_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  logic [AW-1:0] init_cnt_q, init_cnt_d;
`endif

  tdpram_be_merge #(.DW(DW)) u_merge (
    .old_i    (bus.ram_rdata),
    .new_i    (wdata_q),
    .be_i     (be_q),
    .merged_o (merged_s)
  );

  // Next-state and RAM-port decode from the current state and request.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    ready_s     = 1'b0;
    busy_s      = 1'b0;
    ram_wr_s    = 1'b0;
    ram_addr_s  = '0;
    ram_wdata_s = '0;
`ifdef TDPRAM_PA_INIT_CLR_EN
    init_cnt_d  = init_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_s     = 1'b1;
        ram_addr_s  = bus.req_addr;
        ram_wdata_s = bus.req_wdata;
        if (bus.req_valid) begin
          if (!bus.req_wr) begin
            rsp_valid_d = 1'b1;
          end else if (bus.req_be == BE_FULL) begin
            ram_wr_s = 1'b1;
          end else if (bus.req_be == BE_NONE) begin
            // Empty mask: accepted, nothing touches the RAM.
            ram_wr_s = 1'b0;
          end else begin
            // The RAM read of req_addr happens now; merge next cycle.
            addr_d  = bus.req_addr;
            be_d    = bus.req_be;
            wdata_d = bus.req_wdata;
            state_d = S_MERGE;
          end
        end else begin
          rsp_valid_d = 1'b0;
        end
      end
      S_MERGE: begin
        busy_s      = 1'b1;
        ram_wr_s    = 1'b1;
        ram_addr_s  = addr_q;
        ram_wdata_s = merged_s;
        state_d     = S_IDLE;
      end
`ifdef TDPRAM_PA_INIT_CLR_EN
      S_INIT: begin
        busy_s      = 1'b1;
        ram_wr_s    = 1'b1;
        ram_addr_s  = init_cnt_q;
        ram_wdata_s = '0;
        init_cnt_d  = init_cnt_q + AW'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset is synchronous, so the RAM port is held quiet while rst_n is low
  // to keep an abandoned merge from committing at the reset edge.
  assign bus.req_ready = rst_n & ready_s;
  assign bus.busy      = rst_n & busy_s;
  assign bus.ram_wr    = rst_n & ram_wr_s;
  assign bus.ram_addr  = rst_n ? ram_addr_s  : '0;
  assign bus.ram_wdata = rst_n ? ram_wdata_s : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_valid_q ? bus.ram_rdata : '0;

  // State, latched partial-write request and response flag.
  always_ff @(posedge clk_pa) begin
    if (!rst_n) begin
`ifdef TDPRAM_PA_INIT_CLR_EN
      state_q    <= S_INIT;
      init_cnt_q <= '0;
`else
      state_q    <= S_IDLE;
`endif
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
`ifdef TDPRAM_PA_INIT_CLR_EN
      init_cnt_q <= init_cnt_d;
`endif
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_tdpram_pa_rmw_ctrl.sv
// Self-checking bench for tdpram_pa_rmw_ctrl with a behavioural port-A RAM
// (registered read, read-before-write). Table-driven vectors plus directed
// reset and init sequences. Honours TDPRAM_PA_INIT_CLR_EN when defined.
module tb_tdpram_pa_rmw_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
`ifdef TDPRAM_PA_INIT_CLR_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;   // read data for reads, merged word for partial writes
  } vec_t;

  logic clk_pa  = 1'b0;
  logic rst_n   = 1'b0;
  logic preload = 1'b0;
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rd_q;
  int checks   = 0;
  int failures = 0;

  tdpram_pa_rmw_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  tdpram_pa_rmw_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk_pa (clk_pa),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_pa = ~clk_pa;

  // RAM port-A model: one-cycle registered read, old data on same-cycle write.
  always @(posedge clk_pa) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | DW'(i);
    end else if (bus.ram_wr) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    rd_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_be    = 4'h0;
    bus.req_wdata = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_wr    = v.wr;
    bus.req_addr  = v.addr;
    bus.req_be    = v.be;
    bus.req_wdata = v.wdata;
  endtask

  function automatic bit is_partial(input vec_t v);
    return v.wr && (v.be != 4'hF) && (v.be != 4'h0);
  endfunction

  // Checks in the cycle a request is presented (it must be accepted).
  task automatic accept_check(input int i, input vec_t v);
    chk($sformatf("v%0d_ready", i), {31'd0, bus.req_ready}, 32'd1);
    chk($sformatf("v%0d_ram_wr", i), {31'd0, bus.ram_wr},
        {31'd0, (v.wr && v.be == 4'hF)});
    if (!(v.wr && v.be == 4'h0))
      chk($sformatf("v%0d_ram_addr", i), {24'd0, bus.ram_addr}, {24'd0, v.addr});
    if (v.wr && v.be == 4'hF)
      chk($sformatf("v%0d_ram_wdata", i), bus.ram_wdata, v.wdata);
  endtask

  // Checks in the cycle after acceptance: read response or merge cycle.
  task automatic followup(input int i, input vec_t v);
    chk($sformatf("v%0d_rsp_valid", i), {31'd0, bus.rsp_valid}, {31'd0, !v.wr});
    if (!v.wr) chk($sformatf("v%0d_rsp_rdata", i), bus.rsp_rdata, v.exp);
    if (is_partial(v)) begin
      chk($sformatf("v%0d_merge_ready", i), {31'd0, bus.req_ready}, 32'd0);
      chk($sformatf("v%0d_merge_busy", i), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("v%0d_merge_wr", i), {31'd0, bus.ram_wr}, 32'd1);
      chk($sformatf("v%0d_merge_addr", i), {24'd0, bus.ram_addr}, {24'd0, v.addr});
      chk($sformatf("v%0d_merge_wdata", i), bus.ram_wdata, v.exp);
    end
  endtask

  task automatic wait_ready(input string name, input int max);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < max) begin
      @(negedge clk_pa); #1;
      n++;
    end
    chk(name, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk_pa);
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = a;
    bus.req_be = 4'h0; bus.req_wdata = 32'h0;
    #1 chk({name, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk_pa);
    chk({name, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({name, "_rdata"}, bus.rsp_rdata, exp);
    idle_in();
  endtask

  localparam int NV = 16;
  vec_t v [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t prev;
    bit   have_prev;
    int   n;

    v[0]  = '{1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 32'h0};
    v[1]  = '{1'b0, 8'h10, 4'h0, 32'h0,        32'hDEADBEEF};
    v[2]  = '{1'b1, 8'h20, 4'hF, 32'h11223344, 32'h0};
    v[3]  = '{1'b1, 8'h20, 4'h5, 32'hAABBCCDD, 32'h11BB33DD};
    v[4]  = '{1'b0, 8'h20, 4'h0, 32'h0,        32'h11BB33DD};
    v[5]  = '{1'b1, 8'h30, 4'hF, 32'h00000000, 32'h0};
    v[6]  = '{1'b1, 8'h30, 4'h1, 32'h000000FF, 32'h000000FF};
    v[7]  = '{1'b1, 8'h30, 4'h8, 32'hEE000000, 32'hEE0000FF};
    v[8]  = '{1'b0, 8'h30, 4'h0, 32'h0,        32'hEE0000FF};
    v[9]  = '{1'b1, 8'h40, 4'hF, 32'h12345678, 32'h0};
    v[10] = '{1'b1, 8'h40, 4'h0, 32'h00000000, 32'h0};
    v[11] = '{1'b0, 8'h40, 4'h0, 32'h0,        32'h12345678};
    v[12] = '{1'b0, 8'h10, 4'h0, 32'h0,        32'hDEADBEEF};
    v[13] = '{1'b1, 8'h50, 4'hF, 32'hFFFFFFFF, 32'h0};
    v[14] = '{1'b1, 8'h50, 4'h6, 32'h00000000, 32'hFF0000FF};
    v[15] = '{1'b0, 8'h50, 4'h0, 32'h0,        32'hFF0000FF};

    // Reset with nonzero request inputs to show the RAM port stays quiet.
    rst_n = 1'b0;
    preload = 1'b1;
    idle_in();
    bus.req_addr  = 8'h5A;
    bus.req_wdata = 32'h0BAD_F00D;
    repeat (3) @(negedge clk_pa);
    preload = 1'b0;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("rst_ram_addr", {24'd0, bus.ram_addr}, 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    idle_in();
    rst_n = 1'b1;
    #1;
`ifdef TDPRAM_PA_INIT_CLR_EN
    chk("init_busy", {31'd0, bus.busy}, 32'd1);
    chk("init_ram_wr", {31'd0, bus.ram_wr}, 32'd1);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < DEPTH + 8) begin
      @(negedge clk_pa); #1;
      n++;
    end
    chk("init_stall_cycles", n, DEPTH);
`else
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
`endif

    // Preloaded contents survive reset unless the clear sweep is built in.
    read_check("pre_77", 8'h77, INIT_EN ? 32'h0 : 32'hA500_0077);
    read_check("pre_ff", 8'hFF, INIT_EN ? 32'h0 : 32'hA500_00FF);

    // Table-driven sequence, requests presented back to back.
    have_prev = 1'b0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_pa);
      if (have_prev) begin
        followup(i - 1, prev);
        if (is_partial(prev)) begin
          drive(v[i]);
          #1 chk($sformatf("v%0d_stall", i), {31'd0, bus.req_ready}, 32'd0);
          @(negedge clk_pa);
          chk($sformatf("v%0d_post_merge_rsp", i), {31'd0, bus.rsp_valid}, 32'd0);
        end
      end
      drive(v[i]);
      #1 accept_check(i, v[i]);
      prev = v[i];
      have_prev = 1'b1;
    end
    @(negedge clk_pa);
    followup(NV - 1, prev);
    idle_in();
    @(negedge clk_pa);
    chk("rsp_single_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // Reset arriving in the merge cycle drops the pending write.
    @(negedge clk_pa);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h60;
    bus.req_be = 4'hF; bus.req_wdata = 32'hCAFEF00D;
    @(negedge clk_pa);
    bus.req_be = 4'h3; bus.req_wdata = 32'h0000_1234;
    #1 chk("rmw_rst_accept", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk_pa);
    chk("rmw_rst_in_merge", {31'd0, bus.busy}, 32'd1);
    idle_in();
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("rmw_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk_pa);
    rst_n = 1'b1;
    #1 chk("rmw_rst_after_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    wait_ready("rmw_rst_ready", DEPTH + 8);
    read_check("rmw_rst_rd", 8'h60, INIT_EN ? 32'h0 : 32'hCAFEF00D);

    @(negedge clk_pa);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
